// File: rtl/time_set_sequencer_if.sv
// Button, current-time and time-entry signals between the set sequencer and its surroundings.
// The master modport is the sequencer; the slave modport is the buttons and time datapath.
interface time_set_sequencer_if;
    logic       btn_next;
    logic       btn_up;
    logic       btn_down;
    logic [4:0] cur_hrs;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [2:0] mode;
    logic [5:0] val;
    logic       run_en;
    logic       blink;

    modport master (
        input  btn_next, btn_up, btn_down, cur_hrs, cur_min, cur_sec,
        output mode, val, run_en, blink
    );

    modport slave (
        output btn_next, btn_up, btn_down, cur_hrs, cur_min, cur_sec,
        input  mode, val, run_en, blink
    );
endinterface

// File: rtl/time_set_sequencer.sv
// Button-driven time-entry sequencer: RUN -> hours -> minutes -> seconds -> RUN.
// Define AUTO_REPEAT_EN to enable hold-to-repeat stepping on up/down.
module time_set_sequencer #(
    parameter int unsigned BLINK_DIV      = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned REPEAT_DELAY   = 50_000_000,
    parameter int unsigned REPEAT_RATE    = 10_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    time_set_sequencer_if.master bus_io
);
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IdleW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Encoding is chosen so the state value is the mode output directly.
    typedef enum logic [1:0] {
        StRun = 2'd0,
        StSec = 2'd1,
        StMin = 2'd2,
        StHrs = 2'd3
    } state_e;

    state_e            state_q, state_d, state_nxt;
    logic [2:0]        sync1_q, sync2_q, prev_q, btn_rise;  // {down, up, next}
    logic [5:0]        val_q, val_d, load_val, field_max;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [BlinkW-1:0] bcnt_q, bcnt_d;
    logic              blink_q, blink_d;
    logic              rep_up, rep_dn;
    logic              step_up, step_dn, restart, activity;

    assign btn_rise = sync2_q & ~prev_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_phase_q, rep_phase_d, rep_fire, held_alone;

    assign held_alone = sync2_q[1] ^ sync2_q[2];

    // The press cycle itself counts as the first held cycle of the delay.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        if (!held_alone) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (btn_rise[1] || btn_rise[2]) begin
            rep_cnt_d   = RepW'(1);
            rep_phase_d = 1'b0;
        end else if (!rep_phase_q) begin
            if (rep_cnt_q == RepW'(REPEAT_DELAY - 1)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end else if (rep_cnt_q == RepW'(REPEAT_RATE - 1)) begin
            rep_fire  = 1'b1;
            rep_cnt_d = '0;
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign rep_up = rep_fire & sync2_q[1];
    assign rep_dn = rep_fire & sync2_q[2];
`else
    logic unused_rep_params;
    assign unused_rep_params = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    always_comb begin
        state_nxt = StRun;
        load_val  = 6'd0;
        unique case (state_q)
            StRun: begin
                state_nxt = StHrs;
                load_val  = (bus_io.cur_hrs > 5'd23) ? 6'd23 : {1'b0, bus_io.cur_hrs};
            end
            StHrs: begin
                state_nxt = StMin;
                load_val  = bus_io.cur_min;
            end
            StMin: begin
                state_nxt = StSec;
                load_val  = bus_io.cur_sec;
            end
            StSec: begin
                state_nxt = StRun;
                load_val  = val_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        idle_d    = idle_q;
        bcnt_d    = bcnt_q;
        blink_d   = blink_q;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        restart   = 1'b0;
        activity  = btn_rise[1] | btn_rise[2] | rep_up | rep_dn;
        field_max = (state_q == StHrs) ? 6'd23 : 6'd59;

        if (btn_rise[0]) begin
            state_d = state_nxt;
            val_d   = load_val;
            idle_d  = '0;
            restart = 1'b1;
        end else if (state_q != StRun) begin
            // Up and down together cancel; repeat only fires with no fresh press.
            if (btn_rise[1] && !btn_rise[2]) begin
                step_up = 1'b1;
            end else if (btn_rise[2] && !btn_rise[1]) begin
                step_dn = 1'b1;
            end else if (!btn_rise[1] && !btn_rise[2]) begin
                step_up = rep_up;
                step_dn = rep_dn;
            end

            if (activity) begin
                idle_d = '0;
            end else if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
                state_d = StRun;
            end else begin
                idle_d = idle_q + 1'b1;
            end

            if (step_up) begin
                val_d   = (val_q == field_max) ? 6'd0 : val_q + 6'd1;
                restart = 1'b1;
            end else if (step_dn) begin
                val_d   = (val_q == 6'd0) ? field_max : val_q - 6'd1;
                restart = 1'b1;
            end
        end

        if (state_d == StRun) begin
            idle_d  = '0;
            bcnt_d  = '0;
            blink_d = 1'b1;
        end else if (restart) begin
            bcnt_d  = '0;
            blink_d = 1'b1;
        end else if (bcnt_q == BlinkW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
            state_q <= StRun;
            val_q   <= 6'd0;
            idle_q  <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else begin
            sync1_q <= {bus_io.btn_down, bus_io.btn_up, bus_io.btn_next};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            val_q   <= val_d;
            idle_q  <= idle_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    assign bus_io.mode   = {1'b0, state_q};
    assign bus_io.val    = val_q;
    assign bus_io.run_en = (state_q == StRun);
    assign bus_io.blink  = blink_q;
endmodule

// File: tb/tb_time_set_sequencer.sv
// Randomised and directed bench for time_set_sequencer against a behavioural field/value model.
// The model follows AUTO_REPEAT_EN the same way the design build does.
module tb_time_set_sequencer;
    localparam int unsigned BlinkDiv = 4;
    localparam int unsigned Timeout  = 20;
    localparam int unsigned RepDelay = 6;
    localparam int unsigned RepRate  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    time_set_sequencer_if bus_if ();

    time_set_sequencer #(
        .BLINK_DIV     (BlinkDiv),
        .TIMEOUT_CYCLES(Timeout),
        .REPEAT_DELAY  (RepDelay),
        .REPEAT_RATE   (RepRate)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus applied for the next clock edge.
    bit       s_rst, s_next, s_up, s_down;
    int       s_hrs, s_min, s_sec;

    // Model: field 0=run, 1=hours, 2=minutes, 3=seconds.
    int       m_field, m_val, m_idle, m_since, m_held;
    bit [2:0] hist[$];  // raw {down, up, next} per edge, newest first
    bit       m_valid = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_mode();
        return (m_field == 0) ? 0 : 4 - m_field;
    endfunction

    function automatic int exp_blink();
        if (m_field == 0) return 1;
        return ((m_since / BlinkDiv) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_field = 0;
        m_val   = 0;
        m_idle  = 0;
        m_since = 0;
        m_held  = 0;
        hist.delete();
        repeat (3) hist.push_back(3'b000);
    endtask

    task automatic model_update();
        bit [2:0] lvl, prv, rise;
        bit       alone, rep;
        int       dir, fmax;
        if (!s_rst) begin
            model_reset();
            m_valid = 1'b1;
            return;
        end
        hist.push_front({s_down, s_up, s_next});
        if (hist.size() > 4) void'(hist.pop_back());
        // A button reaches the edge detector two edges after it is sampled.
        lvl  = hist[2];
        prv  = hist[3];
        rise = lvl & ~prv;

        alone = lvl[1] ^ lvl[2];
        if (!alone) m_held = 0;
        else if (rise[1] || rise[2]) m_held = 1;
        else m_held++;
        rep = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep = alone && !rise[1] && !rise[2] && m_held >= int'(RepDelay) &&
              ((m_held - int'(RepDelay)) % int'(RepRate) == 0);
`endif

        if (rise[0]) begin
            m_field = (m_field + 1) % 4;
            m_idle  = 0;
            m_since = 0;
            case (m_field)
                1: m_val = (s_hrs > 23) ? 23 : s_hrs;
                2: m_val = s_min;
                3: m_val = s_sec;
                default: ;
            endcase
        end else if (m_field != 0) begin
            fmax = (m_field == 1) ? 23 : 59;
            dir  = 0;
            if (rise[1] && !rise[2]) dir = 1;
            else if (rise[2] && !rise[1]) dir = -1;
            else if (rep) dir = lvl[1] ? 1 : -1;
            if (rise[1] || rise[2] || rep) m_idle = 0;
            else if (m_idle == int'(Timeout) - 1) m_field = 0;
            else m_idle++;
            if (dir != 0) begin
                m_val   = (m_val + dir + fmax + 1) % (fmax + 1);
                m_since = 0;
            end else begin
                m_since++;
            end
        end
        if (m_field == 0) begin
            m_idle  = 0;
            m_since = 0;
        end
    endtask

    task automatic step_cycle();
        @(negedge clk);
        if (m_valid) begin
            check_val("mode", int'(bus_if.mode), exp_mode());
            check_val("val", int'(bus_if.val), m_val);
            check_val("run_en", int'(bus_if.run_en), (m_field == 0) ? 1 : 0);
            check_val("blink", int'(bus_if.blink), exp_blink());
        end
        rst_n           = s_rst;
        bus_if.btn_next = s_next;
        bus_if.btn_up   = s_up;
        bus_if.btn_down = s_down;
        bus_if.cur_hrs  = 5'(s_hrs);
        bus_if.cur_min  = 6'(s_min);
        bus_if.cur_sec  = 6'(s_sec);
        model_update();
    endtask

    // One-cycle press, then enough idle cycles for the registered outputs to reflect it.
    task automatic pulse(input bit nx, input bit up, input bit dn);
        s_next = nx;
        s_up   = up;
        s_down = dn;
        step_cycle();
        s_next = 1'b0;
        s_up   = 1'b0;
        s_down = 1'b0;
        repeat (3) step_cycle();
    endtask

    initial begin
        s_rst  = 1'b0;
        s_next = 1'b0;
        s_up   = 1'b0;
        s_down = 1'b0;
        s_hrs  = 23;
        s_min  = 0;
        s_sec  = 7;

        repeat (2) step_cycle();
        check_val("rst_mode", int'(bus_if.mode), 0);
        check_val("rst_val", int'(bus_if.val), 0);
        check_val("rst_run_en", int'(bus_if.run_en), 1);
        check_val("rst_blink", int'(bus_if.blink), 1);
        s_rst = 1'b1;

        pulse(1'b1, 1'b0, 1'b0);
        check_val("enter_hrs_mode", int'(bus_if.mode), 3);
        check_val("enter_hrs_val", int'(bus_if.val), 23);
        check_val("enter_hrs_run_en", int'(bus_if.run_en), 0);
        pulse(1'b0, 1'b1, 1'b0);
        check_val("hrs_up_wrap", int'(bus_if.val), 0);
        pulse(1'b0, 1'b0, 1'b1);
        check_val("hrs_down_wrap", int'(bus_if.val), 23);
        pulse(1'b1, 1'b0, 1'b0);
        check_val("enter_min_mode", int'(bus_if.mode), 2);
        pulse(1'b0, 1'b0, 1'b1);
        check_val("min_down_wrap", int'(bus_if.val), 59);
        pulse(1'b1, 1'b0, 1'b0);
        check_val("enter_sec_mode", int'(bus_if.mode), 1);
        check_val("enter_sec_val", int'(bus_if.val), 7);
        pulse(1'b1, 1'b0, 1'b0);
        check_val("back_run_mode", int'(bus_if.mode), 0);
        check_val("back_run_en", int'(bus_if.run_en), 1);
        s_hrs = 30;
        pulse(1'b1, 1'b0, 1'b0);
        check_val("hrs_clamp", int'(bus_if.val), 23);

        s_min = 10;
        s_sec = 42;
        pulse(1'b1, 1'b0, 1'b0);
        check_val("min_load", int'(bus_if.val), 10);
        pulse(1'b1, 1'b1, 1'b0);
        check_val("next_beats_up_mode", int'(bus_if.mode), 1);
        check_val("next_beats_up_val", int'(bus_if.val), 42);
        pulse(1'b0, 1'b1, 1'b1);
        check_val("up_down_cancel", int'(bus_if.val), 42);

        repeat (19) step_cycle();
        check_val("pre_timeout_mode", int'(bus_if.mode), 1);
        step_cycle();
        check_val("timeout_mode", int'(bus_if.mode), 0);
        check_val("timeout_run_en", int'(bus_if.run_en), 1);

        s_hrs = 5;
        s_min = 33;
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        s_up = 1'b1;
        step_cycle();
        step_cycle();
        s_rst = 1'b0;
        step_cycle();
        s_rst = 1'b1;
        s_up  = 1'b0;
        step_cycle();
        check_val("mid_edit_rst_mode", int'(bus_if.mode), 0);
        check_val("mid_edit_rst_val", int'(bus_if.val), 0);
        check_val("mid_edit_rst_run_en", int'(bus_if.run_en), 1);

        s_min = 5;
        repeat (3) step_cycle();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        s_up = 1'b1;
        repeat (15) step_cycle();
        s_up = 1'b0;
        repeat (4) step_cycle();
`ifdef AUTO_REPEAT_EN
        check_val("hold_up_val", int'(bus_if.val), 10);
`else
        check_val("hold_up_val", int'(bus_if.val), 6);
`endif

        for (int i = 0; i < 2000; i++) begin
            if ((i % 160) >= 120) begin
                s_next = 1'b0;
                s_up   = 1'b0;
                s_down = 1'b0;
            end else begin
                if ($urandom_range(0, 11) == 0) s_next = ~s_next;
                if ($urandom_range(0, 7) == 0) s_up = ~s_up;
                if ($urandom_range(0, 7) == 0) s_down = ~s_down;
            end
            if ($urandom_range(0, 9) == 0) begin
                s_hrs = $urandom_range(0, 31);
                s_min = $urandom_range(0, 59);
                s_sec = $urandom_range(0, 59);
            end
            s_rst = ($urandom_range(0, 399) != 0);
            step_cycle();
        end
        s_rst = 1'b1;
        step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
